led_ctrl: RTL
=============

Name: led_ctrl

Overview:
- Parametrised successor to the board's direct button-to-LED wiring.
- Each of NUM_CH push-buttons is synchronised and debounced, then edge-detected.
- Each channel drives its LED in a per-channel runtime mode: direct, toggle, blink or off.
- Sits in the board top level, clocked by the single-ended system clock behind the differential input buffer.

Parameters:
- NUM_CH, 5, number of button/LED channels (1..32).
- DEBOUNCE_CYC, 1562500, consecutive cycles a synchronised input must differ from the stable value before it is accepted (10 ms at 156.25 MHz); must be >= 1.
- BLINK_HALF_CYC, 78125000, cycles per blink half-period (0.5 s at 156.25 MHz); must be >= 2.
- Derived, not overridable: DB_W = $clog2(DEBOUNCE_CYC+1) and BL_W = $clog2(BLINK_HALF_CYC).

Ports:
- sys_clk  input  1  system clock; the only clock.
- sys_rst_n  input  1  reset, synchronous, active-low.
- btn_i  input  NUM_CH  raw asynchronous button levels, 1 = pressed.
- mode_i  input  2*NUM_CH  per-channel mode; bits [2i+1:2i] belong to channel i. Quasi-static, sampled every cycle.
- led_o  output  NUM_CH  LED drive, 1 = on, registered.
- press_o  output  NUM_CH  one-cycle pulse per accepted press (debounced rising edge), registered.

Behaviour:
- Reset: reset is synchronous and active-low, applied on a sys_clk edge while sys_rst_n = 0. All of the following clear to 0: synchroniser flops, debounce counters, stable levels, toggle states, blink prescaler, blink phase, led_o and press_o. Reset asserted mid-count discards any partial debounce or blink progress.
- Synchroniser: 2 flops per channel, btn_i to s1 to s2.
- Debounce, on each edge:
  - If s2 == stable, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYC-1, then stable <= s2 and cnt <= 0.
  - Else cnt <= cnt+1.
  - Any return of s2 to the stable level before acceptance restarts the count. Bounces shorter than DEBOUNCE_CYC cycles are therefore invisible.
- Press detect: press_o[i] is 1 for exactly the cycle following the edge at which stable[i] goes 0 to 1. Releases generate no pulse.
- Toggle state: t[i] inverts on every press, in all modes. It is preserved across mode changes and cleared only by reset.
- Blink timebase: one shared prescaler counts 0..BLINK_HALF_CYC-1 and wraps. phase inverts on each wrap. It free-runs from reset regardless of mode.
- Mode encoding, in the cycle after the inputs change:
  - 2'b00 DIRECT: led_o = stable.
  - 2'b01 TOGGLE: led_o = t.
  - 2'b10 BLINK: led_o = t & phase, so a press arms or disarms blinking.
  - 2'b11 OFF: led_o = 0, while debounce, press_o and t keep running.
- Latency: btn_i change before edge k gives a stable change at edge k+1+DEBOUNCE_CYC, press_o/t at that same edge, and led_o at edge k+2+DEBOUNCE_CYC.
- Simultaneous events:
  - Channels are fully independent; simultaneous presses on several channels each pulse in the same cycle.
  - A mode change in the same cycle as a press: the press updates t, and led_o uses the new mode and the new t on the next edge.
- No combinational path from any input to any output.

Decomposition:
- Package led_pkg holds:
  - the typedef led_mode_e (2-bit enum: LED_DIRECT, LED_TOGGLE, LED_BLINK, LED_OFF);
  - the default constants CLK_HZ = 156250000, DEBOUNCE_MS = 10 and BLINK_MS = 500.
- Sub-module led_debounce (parameter DEBOUNCE_CYC; ports sys_clk, sys_rst_n, raw_i, stable_o, rise_o) contains the synchroniser, counter and press detect.
- led_ctrl instantiates led_debounce NUM_CH times in a generate loop. It owns the toggle flops, the shared blink prescaler and the output mux.

Test Plan (NUM_CH = 2, DEBOUNCE_CYC = 4, BLINK_HALF_CYC = 8):
1. Reset: hold sys_rst_n = 0 for 3 edges with btn_i = 2'b11 -> led_o = 0 and press_o = 0 throughout; after release, led_o in DIRECT mode rises 6 edges after sampling.
2. DIRECT latency: mode = 00, btn_i[0] rises before edge 0 -> press_o[0] = 1 only after edge 5, led_o[0] = 1 from edge 6. btn_i[0] falls -> led_o[0] = 0 six edges later, with no press_o pulse.
3. Bounce rejection: btn_i[1] pulses high for 3 cycles, then pulses high for 2 cycles -> stable, press_o[1] and led_o[1] stay 0. A 4-cycle-stable high is accepted.
4. TOGGLE: mode = 01; apply three clean presses -> led_o sequence 1, 0, 1, with exactly 3 press_o pulses. Switching to OFF then back to TOGGLE -> led_o returns to 1.
5. BLINK: mode = 10, one press -> led_o follows phase with period 16 cycles (8 on, 8 off). A second press -> led_o held at 0.
6. Mid-operation reset: assert sys_rst_n = 0 while a debounce count is at 2 and t = 1 -> the next edge clears all state. A held button is then re-accepted after the full DEBOUNCE_CYC count.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and board-level timing defaults for the button/LED controller.
// Default cycle counts are derived from the system clock frequency.
package led_pkg;

  typedef enum logic [1:0] {
    LED_DIRECT = 2'b00,
    LED_TOGGLE = 2'b01,
    LED_BLINK  = 2'b10,
    LED_OFF    = 2'b11
  } led_mode_e;

  localparam int CLK_HZ      = 156250000;
  localparam int DEBOUNCE_MS = 10;
  localparam int BLINK_MS    = 500;

  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int DEFAULT_DEBOUNCE_CYC   = ms_to_cycles(DEBOUNCE_MS);
  localparam int DEFAULT_BLINK_HALF_CYC = ms_to_cycles(BLINK_MS);

  // Per-channel output selection from the current mode and channel state.
  function automatic logic led_select(input led_mode_e mode, input logic stable,
                                      input logic toggle, input logic phase);
    logic led;
    led = 1'b0;
    case (mode)
      LED_DIRECT: led = stable;
      LED_TOGGLE: led = toggle;
      LED_BLINK:  led = toggle & phase;
      LED_OFF:    led = 1'b0;
      default:    led = 1'b0;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/led_debounce.sv
// One button channel: two-flop synchroniser, debounce counter and press detect.
// rise_o strobes in the cycle before the edge at which a 0->1 level is accepted.
module led_debounce
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

  logic            s1;
  logic            s2;
  logic [DB_W-1:0] cnt;
  logic            accept;

  // Acceptance fires only on the last cycle of an unbroken run of differing samples.
  assign accept = (s2 != stable_o) && (cnt == DB_W'(DEBOUNCE_CYC - 1));
  assign rise_o = accept & s2;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable_o <= 1'b0;
      cnt      <= '0;
    end else begin
      s1 <= raw_i;
      s2 <= s1;
      if (s2 == stable_o) begin
        cnt <= '0;
      end else if (accept) begin
        stable_o <= s2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_ctrl.sv
// Multi-channel button-to-LED controller with direct, toggle, blink and off modes.
// Owns toggle state, the shared blink timebase and the registered output mux.
module led_ctrl
  import led_pkg::*;
#(
  parameter int NUM_CH         = 5,
  parameter int DEBOUNCE_CYC   = DEFAULT_DEBOUNCE_CYC,
  parameter int BLINK_HALF_CYC = DEFAULT_BLINK_HALF_CYC
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_CH-1:0]   btn_i,
  input  logic [2*NUM_CH-1:0] mode_i,
  output logic [NUM_CH-1:0]   led_o,
  output logic [NUM_CH-1:0]   press_o
);

  localparam int BL_W = $clog2(BLINK_HALF_CYC);

  logic [NUM_CH-1:0] stable;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] toggle;
  logic [NUM_CH-1:0] led_next;
  logic [BL_W-1:0]   prescale;
  logic              phase;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .raw_i    (btn_i[i]),
      .stable_o (stable[i]),
      .rise_o   (rise[i])
    );
  end

  // Blink timebase free-runs from reset, independent of any channel mode.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      prescale <= '0;
      phase    <= 1'b0;
    end else if (prescale == BL_W'(BLINK_HALF_CYC - 1)) begin
      prescale <= '0;
      phase    <= ~phase;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  always_comb begin
    led_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      led_next[i] = led_select(led_mode_e'(mode_i[2*i +: 2]), stable[i], toggle[i], phase);
    end
  end

  // Toggle state advances on every accepted press whatever the mode, so OFF/BLINK keep it.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      toggle  <= '0;
      press_o <= '0;
      led_o   <= '0;
    end else begin
      toggle  <= toggle ^ rise;
      press_o <= rise;
      led_o   <= led_next;
    end
  end

endmodule
